// File: rtl/ct_f_spsram_256x52_ctrl.sv
// Request front-end for a 256x52 single-port SRAM macro.
//
// After reset or a clear request the block zero-fills every entry, one per
// cycle, then enters RUN. In RUN it accepts read/write requests on a
// valid/ready interface. Each write is masked per 26-bit half-word. Read data
// comes back through a 2-entry response FIFO that honours backpressure.
//
// Ports:
//   CLK, RST        clock (rising edge) and synchronous active-high reset
//   clear_req       pulse that restarts the zero-fill sweep
//   init_done       high while in RUN (sweep complete)
//   req_*           request channel (valid/ready, write flag, addr, data, mask)
//   resp_*          response channel (valid/ready, data at FIFO head)
//   sram_A/CEN/GWEN/WEN/D   macro control pins (active-low enables)
//   sram_Q          macro read data, valid the cycle after a read access
module ct_f_spsram_256x52_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 52,
  parameter int unsigned WRAP_SIZE  = 26
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clear_req,
  output logic                  init_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_A,
  output logic                  sram_CEN,
  output logic                  sram_GWEN,
  output logic [DATA_WIDTH-1:0] sram_WEN,
  output logic [DATA_WIDTH-1:0] sram_D,
  input  logic [DATA_WIDTH-1:0] sram_Q
);

  // StReset holds the pins idle for the first cycle after reset so that the
  // sweep starts one cycle later with a clean counter.
  typedef enum logic [1:0] {StReset, StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];

  logic                  run;
  logic                  sweeping;
  logic                  pop;
  logic                  push;
  logic                  req_fire;
  logic                  rd_fire;
  logic                  wr_fire;
  logic [2:0]            occ;
  logic [DATA_WIDTH-1:0] wen_mask;

  assign run      = (state_q == StRun) && !RST;
  assign sweeping = (state_q == StInit) && !RST;

  assign resp_valid = (count_q != 2'd0) && !RST;
  assign resp_rdata = fifo_q[rd_ptr_q];
  assign pop        = resp_valid && resp_ready;
  // The macro returns data one cycle after a read access, independent of state.
  assign push       = rd_pend_q;

  // Occupancy the FIFO will have once this cycle's pop and the pending push
  // have both landed; a new read is only safe if a slot remains for it.
  assign occ = 3'(count_q) + 3'(rd_pend_q) - 3'(pop);

  assign req_ready = run && (req_write || (occ < 3'd2));
  assign req_fire  = req_valid && req_ready;
  assign rd_fire   = req_fire && !req_write;
  assign wr_fire   = req_fire && req_write;
  assign init_done = run;

  assign wen_mask = {{(DATA_WIDTH - WRAP_SIZE){~req_wmask[1]}}, {WRAP_SIZE{~req_wmask[0]}}};

  // Macro pin drive.
  always_comb begin
    sram_A    = req_addr;
    sram_D    = req_wdata;
    sram_CEN  = 1'b1;
    sram_GWEN = 1'b1;
    sram_WEN  = '1;
    if (sweeping) begin
      sram_A    = cnt_q;
      sram_D    = '0;
      sram_CEN  = 1'b0;
      sram_GWEN = 1'b0;
      sram_WEN  = '0;
    end else if (run) begin
      if (wr_fire) begin
        // An all-zero mask is accepted but never reaches the macro.
        sram_CEN  = (req_wmask == 2'b00);
        sram_GWEN = 1'b0;
        sram_WEN  = wen_mask;
      end else if (rd_fire) begin
        sram_CEN = 1'b0;
      end
    end
  end

  // State and sweep counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StReset: begin
        state_d = StInit;
        cnt_d   = '0;
      end
      StInit: begin
        if (clear_req) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == '1) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (clear_req) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StReset;
        cnt_d   = '0;
      end
    endcase
  end

  // Response FIFO and read tracking.
  always_comb begin
    rd_pend_d = rd_fire;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fifo_d    = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = sram_Q;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StReset;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Data storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge CLK) begin
    fifo_q[0] <= fifo_d[0];
    fifo_q[1] <= fifo_d[1];
  end

endmodule

// File: doc/ct_f_spsram_256x52_ctrl.md
Name: ct_f_spsram_256x52_ctrl

Overview:
Request front-end that sits directly upstream of the 256x52 single-port FPGA SRAM macro. It drives the macro's A/CEN/GWEN/WEN/D pins and consumes its Q output. After reset, or on a clear request, it zero-initialises all 256 entries. In normal operation it accepts read/write requests on a valid/ready interface, performs half-word (26-bit) masked writes, and returns read data through a 2-entry response FIFO with backpressure.

Parameters:
ADDR_WIDTH, 8, SRAM address width; depth is 2^ADDR_WIDTH.
DATA_WIDTH, 52, SRAM word width.
WRAP_SIZE, 26, half-word width; one write-mask bit per half.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  synchronous reset, active-high.
clear_req  in  1  pulse; restarts the zero-init sweep.
init_done  out  1  high when the sweep is complete and the block is in RUN.
req_valid  in  1  request valid.
req_ready  out  1  request accepted when req_valid && req_ready.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  word address.
req_wdata  in  DATA_WIDTH  write data.
req_wmask  in  2  bit0 = D[25:0], bit1 = D[51:26]; 1 = write this half.
resp_valid  out  1  read data valid.
resp_ready  in  1  consumer accepts read data.
resp_rdata  out  DATA_WIDTH  read data, FIFO head.
sram_A  out  ADDR_WIDTH  to macro A.
sram_CEN  out  1  to macro CEN, active-low.
sram_GWEN  out  1  to macro GWEN, active-low global write.
sram_WEN  out  DATA_WIDTH  to macro WEN, active-low per bit.
sram_D  out  DATA_WIDTH  to macro D.
sram_Q  in  DATA_WIDTH  from macro Q; valid the cycle after a read access.

Behaviour:
- States: INIT and RUN. RST forces INIT, init counter = 0, FIFO empty, rd_pend = 0.
- Outputs while RST is high and in the first cycle after reset:
  - init_done = 0, req_ready = 0, resp_valid = 0.
  - sram_CEN = 1, sram_GWEN = 1, sram_WEN all ones.
- INIT state:
  - Each cycle drive sram_CEN = 0, GWEN = 0, WEN = 0, D = 0, A = counter; then counter++.
  - After writing address 255, go to RUN next cycle. The sweep takes exactly 256 cycles.
  - init_done rises in the first RUN cycle. req_ready = 0 throughout INIT.
- RUN state, SRAM pins are driven combinationally in the handshake cycle t. When idle, sram_CEN = 1 and GWEN/WEN are all ones.
- Write:
  - A = req_addr, D = req_wdata, GWEN = 0.
  - WEN[25:0] = {26{~req_wmask[0]}}; WEN[51:26] = {26{~req_wmask[1]}}.
  - CEN = 0 only if req_wmask != 0. A mask of 2'b00 is accepted and dropped with no access.
  - Writes never wait on the response path.
- Read:
  - A = req_addr, CEN = 0, GWEN = 1, WEN all ones.
  - rd_pend is set for cycle t+1. In t+1, sram_Q is pushed into the FIFO.
  - resp_valid is high from t+2 (read latency 2 cycles).
- req_ready in RUN:
  - 1 if req_write.
  - For reads, 1 iff (fifo_count - pop_this_cycle + rd_pend) < 2, where pop = resp_valid && resp_ready.
  - This sustains one read per cycle when resp_ready = 1, and guarantees the rd_pend push never overflows.
- FIFO:
  - 2 entries, in-order.
  - Simultaneous push and pop is allowed.
  - resp_rdata is stable while resp_valid && !resp_ready.
- Ordering: a read accepted after a write to the same address returns the newly written data, including back-to-back cycles.
- clear_req:
  - Sampled high in RUN: go to INIT next cycle with counter = 0; init_done drops that cycle.
  - Sampled high in INIT: restart the counter at 0.
  - A request handshaking in the same cycle as clear_req in RUN still completes.
  - An rd_pend push still occurs; FIFO contents are kept and continue to drain during INIT.
- Reset mid-operation discards the FIFO, rd_pend and the counter; no response is produced for an in-flight read.

Test Plan:
- Reset 5 cycles, then idle:
  - sram_CEN = 0 for exactly 256 consecutive cycles with A = 0..255, D = 0, GWEN = 0.
  - init_done = 1 on cycle 257; any read afterwards returns 52'h0.
- Writes with masks:
  - Write addr 0x10, data 52'hF_FFFF_FFFF_FFFF, mask 2'b11.
  - Write addr 0x10, data 0, mask 2'b01.
  - Read addr 0x10 -> 52'hF_FFFF_FC00_0000, resp_valid 2 cycles after the read handshake.
- Read throughput: 8 back-to-back reads of addr 0..7 with resp_ready = 1 -> req_ready stays 1 and 8 responses arrive in consecutive cycles, in order.
- Backpressure:
  - Hold resp_ready = 0 and issue reads.
  - Exactly 2 reads are accepted, then req_ready = 0 for reads; a write is still accepted.
  - Release resp_ready -> both responses drain in order, then reads resume.
- Write-then-read: write addr 0xFF with 52'h1_2345_6789_ABCD, mask 2'b11, then read 0xFF next cycle -> 52'h1_2345_6789_ABCD.
- clear_req mid-traffic:
  - Assert clear_req in the same cycle as a read handshake of addr 0x10 holding 52'hA.
  - The response 52'hA is still delivered.
  - The sweep runs 256 cycles, then a read of 0x10 returns 0.
  - A write with mask 2'b00 produces no CEN pulse.
